// File: rtl/operand_collector.sv
// Packs a 16-bit valid/ready word stream into groups of four parallel operands,
// with a one-group output register. Optional partial-group flush: OPC_FLUSH_EN.
module operand_collector (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
`ifdef OPC_FLUSH_EN
  input  logic        flush,
  output logic [2:0]  out_words,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] in1,
  output logic [15:0] in2,
  output logic [15:0] in3,
  output logic [15:0] in4,
  output logic [7:0]  grp_cnt
);

  logic [1:0]        cnt_q, cnt_d;
  logic [2:0][15:0]  stage_q, stage_d;
  logic [3:0][15:0]  grp_q, grp_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        grp_cnt_q, grp_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic [2:0]        words_q, words_d;

  logic accept, drain, load_full, load_part;

  // Only the 4th word needs the output register, so only it can be stalled.
  assign s_ready   = !(cnt_q == 2'd3 && out_valid_q && !out_ready) && !flush_pend_q;
  assign accept    = s_valid && s_ready;
  assign drain     = out_valid_q && out_ready;
  assign load_full = accept && (cnt_q == 2'd3);

`ifdef OPC_FLUSH_EN
  logic [2:0] cnt_after;
  assign load_part = flush_pend_q && (!out_valid_q || out_ready);
  assign cnt_after = {1'b0, cnt_q} + {2'b00, accept};
`else
  assign load_part = 1'b0;
`endif

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    cnt_d        = cnt_q;
    stage_d      = stage_q;
    grp_d        = grp_q;
    out_valid_d  = out_valid_q;
    grp_cnt_d    = grp_cnt_q + {7'd0, drain};
    flush_pend_d = flush_pend_q;
    words_d      = words_q;

    if (accept) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    stage_d[0] = s_data;
        2'd1:    stage_d[1] = s_data;
        2'd2:    stage_d[2] = s_data;
        default: stage_d    = stage_q;
      endcase
    end

    if (load_full) begin
      // The last word bypasses staging and goes straight to in4.
      grp_d   = {s_data, stage_q[2], stage_q[1], stage_q[0]};
      words_d = 3'd4;
    end

`ifdef OPC_FLUSH_EN
    if (load_part) begin
      grp_d[0]     = stage_q[0];
      grp_d[1]     = (cnt_q > 2'd1) ? stage_q[1] : 16'd0;
      grp_d[2]     = (cnt_q > 2'd2) ? stage_q[2] : 16'd0;
      grp_d[3]     = 16'd0;
      words_d      = {1'b0, cnt_q};
      cnt_d        = 2'd0;
      flush_pend_d = 1'b0;
    end else if (flush && !load_full && cnt_after != 3'd0) begin
      flush_pend_d = 1'b1;
    end
`endif

    if (load_full || load_part) begin
      out_valid_d = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the staging
  // registers are reset too so a flushed partial group never exposes stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 2'd0;
      stage_q      <= '0;
      grp_q        <= '0;
      out_valid_q  <= 1'b0;
      grp_cnt_q    <= 8'd0;
      flush_pend_q <= 1'b0;
      words_q      <= 3'd0;
    end else begin
      cnt_q        <= cnt_d;
      stage_q      <= stage_d;
      grp_q        <= grp_d;
      out_valid_q  <= out_valid_d;
      grp_cnt_q    <= grp_cnt_d;
      flush_pend_q <= flush_pend_d;
      words_q      <= words_d;
    end
  end

  assign out_valid = out_valid_q;
  assign in1       = grp_q[0];
  assign in2       = grp_q[1];
  assign in3       = grp_q[2];
  assign in4       = grp_q[3];
  assign grp_cnt   = grp_cnt_q;

`ifdef OPC_FLUSH_EN
  assign out_words = words_q;
`else
  logic unused_words;
  assign unused_words = ^words_q;
`endif

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector with a group scoreboard; flush
// scenarios run only when OPC_FLUSH_EN is defined.
module tb_operand_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] in1, in2, in3, in4;
  logic [7:0]  grp_cnt;
`ifdef OPC_FLUSH_EN
  logic        flush = 1'b0;
  logic [2:0]  out_words;
`endif

  operand_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
`ifdef OPC_FLUSH_EN
    .flush     (flush),
    .out_words (out_words),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .grp_cnt   (grp_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][15:0] op;
    logic [2:0]       words;
  } grp_t;

  grp_t        sb[$];
  logic [15:0] mbuf[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_deliv = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_word(input logic [15:0] d);
    grp_t e;
    mbuf.push_back(d);
    if (mbuf.size() == 4) begin
      for (int i = 0; i < 4; i++) e.op[i] = mbuf[i];
      e.words = 3'd4;
      sb.push_back(e);
      mbuf.delete();
    end
  endtask

  task automatic model_flush();
    grp_t e;
    if (mbuf.size() > 0) begin
      e.op = '0;
      for (int i = 0; i < mbuf.size(); i++) e.op[i] = mbuf[i];
      e.words = 3'(mbuf.size());
      sb.push_back(e);
      mbuf.delete();
    end
  endtask

  // Scoreboard consumer: inputs settle at posedge+1, so the negedge sees the
  // handshake that the next rising edge will act on.
  always @(negedge clk) begin
    grp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_group", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("sb_in1", 32'(in1), 32'(e.op[0]));
        check("sb_in2", 32'(in2), 32'(e.op[1]));
        check("sb_in3", 32'(in3), 32'(e.op[2]));
        check("sb_in4", 32'(in4), 32'(e.op[3]));
        check("sb_grp_cnt", 32'(grp_cnt), 32'(n_deliv % 256));
`ifdef OPC_FLUSH_EN
        check("sb_out_words", 32'(out_words), 32'(e.words));
`endif
        n_deliv++;
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic fl, output int stalls);
    stalls = 0;
    s_valid = 1'b1;
    s_data  = d;
`ifdef OPC_FLUSH_EN
    flush = fl;
`endif
    @(negedge clk);
    while (!s_ready && stalls < 200) begin
      @(negedge clk);
      stalls++;
    end
    if (!s_ready) check("send_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
`ifdef OPC_FLUSH_EN
    flush = 1'b0;
`endif
    if (s_ready || stalls < 200) begin
      model_word(d);
      if (fl) model_flush();
    end
  endtask

  task automatic send4(input logic [15:0] a, b, c, d);
    int st;
    send(a, 1'b0, st);
    send(b, 1'b0, st);
    send(c, 1'b0, st);
    send(d, 1'b0, st);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    s_valid   = 1'b0;
    out_ready = 1'b0;
`ifdef OPC_FLUSH_EN
    flush = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ops", {in1, in2} | {in3, in4}, 32'd0);
    check("rst_grp_cnt", 32'(grp_cnt), 32'd0);
`ifdef OPC_FLUSH_EN
    check("rst_out_words", 32'(out_words), 32'd0);
`endif
    sb.delete();
    mbuf.delete();
    n_deliv = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int stall_total;

    // Reset mid-group, then one group under backpressure.
    do_reset();
    send(16'h00AA, 1'b0, st);
    send(16'h00BB, 1'b0, st);
    do_reset();
    send4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_in1", 32'(in1), 32'h1);
    check("first_in2", 32'(in2), 32'h2);
    check("first_in3", 32'(in3), 32'h3);
    check("first_in4", 32'(in4), 32'h4);
    repeat (2) @(negedge clk);
    check("first_grp_cnt_held", 32'(grp_cnt), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("first_drained_valid", 32'(out_valid), 32'd0);
    check("first_drained_cnt", 32'(grp_cnt), 32'd1);

    // Streaming: 16 back-to-back words, no stall expected.
    do_reset();
    out_ready = 1'b1;
    stall_total = 0;
    for (int i = 0; i < 16; i++) begin
      send(16'(i), 1'b0, st);
      stall_total += st;
    end
    check("stream_stalls", 32'(stall_total), 32'd0);
    @(posedge clk); #1;
    check("stream_grp_cnt", 32'(grp_cnt), 32'd4);
    check("stream_idle", 32'(out_valid), 32'd0);

    // Backpressure: 4th word of the second group is held off.
    do_reset();
    for (int i = 0; i < 7; i++) send(16'(i), 1'b0, st);
    s_valid = 1'b1;
    s_data  = 16'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_s_ready", 32'(s_ready), 32'd0);
      check("bp_stable_lo", {in1, in2}, {16'd0, 16'd1});
      check("bp_stable_hi", {in3, in4}, {16'd2, 16'd3});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_comb", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    model_word(16'd7);
    check("bp_no_gap", 32'(out_valid), 32'd1);
    check("bp_next_lo", {in1, in2}, {16'd4, 16'd5});
    check("bp_next_hi", {in3, in4}, {16'd6, 16'd7});
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_grp_cnt", 32'(grp_cnt), 32'd2);

    // Boundary operand values.
    send4(16'hFFFF, 16'h8000, 16'h0000, 16'h7FFF);
    check("bnd_lo", {in1, in2}, {16'hFFFF, 16'h8000});
    check("bnd_hi", {in3, in4}, {16'h0000, 16'h7FFF});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Group counter wrap after 257 groups.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 257 * 4; i++) send(16'(i * 7), 1'b0, st);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("wrap_grp_cnt", 32'(grp_cnt), 32'd1);

`ifdef OPC_FLUSH_EN
    // Partial group via flush.
    do_reset();
    send(16'hAAAA, 1'b0, st);
    send(16'hBBBB, 1'b0, st);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_flush();
    check("fl_pend_blocks", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check("fl_valid", 32'(out_valid), 32'd1);
    check("fl_lo", {in1, in2}, {16'hAAAA, 16'hBBBB});
    check("fl_hi", {in3, in4}, 32'd0);
    check("fl_words", 32'(out_words), 32'd2);
    check("fl_ready_back", 32'(s_ready), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Flush together with the 4th word forms a normal group.
    send(16'h0011, 1'b0, st);
    send(16'h0022, 1'b0, st);
    send(16'h0033, 1'b0, st);
    send(16'h0044, 1'b1, st);
    check("fl4_words", 32'(out_words), 32'd4);
    check("fl4_in4", 32'(in4), 32'h44);
    @(negedge clk);
    check("fl4_no_pend", 32'(s_ready), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Flush blocked behind a pending group.
    send4(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    send(16'h0505, 1'b0, st);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_flush();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flb_s_ready", 32'(s_ready), 32'd0);
      check("flb_words_held", 32'(out_words), 32'd4);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("flb_valid", 32'(out_valid), 32'd1);
    check("flb_ops", {in1, in2, in3, in4}, 64'h0505_0000_0000_0000);
    check("flb_words", 32'(out_words), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
